// File: rtl/lc3_isdu.sv
// LC-3 instruction sequencing/decode unit: Moore FSM that drives every datapath strobe.
// Optional build macro ISDU_ILLEGAL_HALT_EN: undefined opcodes halt instead of acting as NOPs.
module lc3_isdu #(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       continue_i,
  input  logic [3:0] opcode,
  input  logic       ir5,
  input  logic       ir11,
  input  logic       ben,
  output logic       ld_mar,
  output logic       ld_mdr,
  output logic       ld_ir,
  output logic       ld_ben,
  output logic       ld_cc,
  output logic       ld_reg,
  output logic       ld_pc,
  output logic       ld_led,
  output logic       gate_pc,
  output logic       gate_mdr,
  output logic       gate_alu,
  output logic       gate_marmux,
  output logic [1:0] pcmux,
  output logic       drmux,
  output logic       sr1mux,
  output logic       sr2mux,
  output logic       addr1mux,
  output logic [1:0] addr2mux,
  output logic [1:0] aluk,
  output logic       mem_oe,
  output logic       mem_we,
  output logic       halted
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    S_HALTED,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_ALU,
    S_NOT,
    S_BR_CHK,
    S_BR_TAKE,
    S_JMP,
    S_JSR,
    S_JSR2,
    S_LDR1,
    S_LDR2,
    S_LDR3,
    S_STR1,
    S_STR2,
    S_STR3,
    S_PAUSE1,
    S_PAUSE2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             mem_state;
  logic             cnt_done;
  logic             and_q;
  logic             imm_q;
  logic             jsr_q;

  assign mem_state = (state == S_FETCH2) || (state == S_LDR2) || (state == S_STR3);
  assign cnt_done  = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_HALTED;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory wait counter: zero outside memory states, wraps on the exit cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (mem_state && !cnt_done) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Instruction mode bits captured in DECODE so execute outputs decode from registers only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_q <= 1'b0;
      imm_q <= 1'b0;
      jsr_q <= 1'b0;
    end else if (state == S_DECODE) begin
      and_q <= (opcode == 4'b0101);
      imm_q <= ir5;
      jsr_q <= ir11;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_HALTED:  if (run) state_nxt = S_FETCH1;
      S_FETCH1:  state_nxt = S_FETCH2;
      S_FETCH2:  if (cnt_done) state_nxt = S_FETCH3;
      S_FETCH3:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'b0001, 4'b0101: state_nxt = S_ALU;
          4'b1001:          state_nxt = S_NOT;
          4'b0000:          state_nxt = S_BR_CHK;
          4'b1100:          state_nxt = S_JMP;
          4'b0100:          state_nxt = S_JSR;
          4'b0110:          state_nxt = S_LDR1;
          4'b0111:          state_nxt = S_STR1;
          4'b1101:          state_nxt = S_PAUSE1;
`ifdef ISDU_ILLEGAL_HALT_EN
          default:          state_nxt = S_HALTED;
`else
          default:          state_nxt = S_FETCH1;
`endif
        endcase
      end
      S_ALU:     state_nxt = S_FETCH1;
      S_NOT:     state_nxt = S_FETCH1;
      S_BR_CHK:  state_nxt = ben ? S_BR_TAKE : S_FETCH1;
      S_BR_TAKE: state_nxt = S_FETCH1;
      S_JMP:     state_nxt = S_FETCH1;
      S_JSR:     state_nxt = S_JSR2;
      S_JSR2:    state_nxt = S_FETCH1;
      S_LDR1:    state_nxt = S_LDR2;
      S_LDR2:    if (cnt_done) state_nxt = S_LDR3;
      S_LDR3:    state_nxt = S_FETCH1;
      S_STR1:    state_nxt = S_STR2;
      S_STR2:    state_nxt = S_STR3;
      S_STR3:    if (cnt_done) state_nxt = S_FETCH1;
      S_PAUSE1:  if (continue_i) state_nxt = S_PAUSE2;
      S_PAUSE2:  if (!continue_i) state_nxt = S_FETCH1;
      default:   state_nxt = S_HALTED;
    endcase
  end

  // Moore output decode
  always_comb begin
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    ld_ir       = 1'b0;
    ld_ben      = 1'b0;
    ld_cc       = 1'b0;
    ld_reg      = 1'b0;
    ld_pc       = 1'b0;
    ld_led      = 1'b0;
    gate_pc     = 1'b0;
    gate_mdr    = 1'b0;
    gate_alu    = 1'b0;
    gate_marmux = 1'b0;
    pcmux       = 2'd0;
    drmux       = 1'b0;
    sr1mux      = 1'b0;
    sr2mux      = 1'b0;
    addr1mux    = 1'b0;
    addr2mux    = 2'd0;
    aluk        = 2'd0;
    mem_oe      = 1'b0;
    mem_we      = 1'b0;
    halted      = 1'b0;
    case (state)
      S_HALTED: halted = 1'b1;
      S_FETCH1: begin
        ld_mar  = 1'b1;
        gate_pc = 1'b1;
        ld_pc   = 1'b1;
      end
      S_FETCH2, S_LDR2: begin
        mem_oe = 1'b1;
        ld_mdr = 1'b1;
      end
      S_FETCH3: begin
        gate_mdr = 1'b1;
        ld_ir    = 1'b1;
      end
      S_DECODE: ld_ben = 1'b1;
      S_ALU: begin
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
        gate_alu = 1'b1;
        sr1mux   = 1'b1;
        sr2mux   = imm_q;
        aluk     = and_q ? 2'd1 : 2'd0;
      end
      S_NOT: begin
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
        gate_alu = 1'b1;
        sr1mux   = 1'b1;
        aluk     = 2'd2;
      end
      S_BR_TAKE: begin
        ld_pc    = 1'b1;
        pcmux    = 2'd2;
        addr2mux = 2'd2;
      end
      S_JMP: begin
        ld_pc    = 1'b1;
        pcmux    = 2'd1;
        gate_alu = 1'b1;
        sr1mux   = 1'b1;
        aluk     = 2'd3;
      end
      S_JSR: begin
        ld_reg  = 1'b1;
        drmux   = 1'b1;
        gate_pc = 1'b1;
      end
      S_JSR2: begin
        ld_pc = 1'b1;
        if (jsr_q) begin
          pcmux    = 2'd2;
          addr2mux = 2'd3;
        end else begin
          pcmux    = 2'd1;
          gate_alu = 1'b1;
          sr1mux   = 1'b1;
          aluk     = 2'd3;
        end
      end
      S_LDR1, S_STR1: begin
        ld_mar      = 1'b1;
        gate_marmux = 1'b1;
        addr1mux    = 1'b1;
        sr1mux      = 1'b1;
        addr2mux    = 2'd1;
      end
      S_LDR3: begin
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
        gate_mdr = 1'b1;
      end
      S_STR2: begin
        ld_mdr   = 1'b1;
        gate_alu = 1'b1;
        aluk     = 2'd3;
      end
      S_STR3:   mem_we = 1'b1;
      S_PAUSE1: ld_led = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_lc3_isdu.sv
// Randomized bench for lc3_isdu: per-instruction expected strobe sequences built from the ISA rules.
module tb_lc3_isdu;

  localparam int unsigned MW = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       continue_i = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       ir5 = 1'b0;
  logic       ir11 = 1'b0;
  logic       ben = 1'b0;
  logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
  logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic [1:0] pcmux, addr2mux, aluk;
  logic       drmux, sr1mux, sr2mux, addr1mux, mem_oe, mem_we, halted;
  logic [24:0] obs;

  lc3_isdu #(.MEM_WAIT(MW)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .continue_i(continue_i),
    .opcode(opcode), .ir5(ir5), .ir11(ir11), .ben(ben),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_ben(ld_ben),
    .ld_cc(ld_cc), .ld_reg(ld_reg), .ld_pc(ld_pc), .ld_led(ld_led),
    .gate_pc(gate_pc), .gate_mdr(gate_mdr), .gate_alu(gate_alu), .gate_marmux(gate_marmux),
    .pcmux(pcmux), .drmux(drmux), .sr1mux(sr1mux), .sr2mux(sr2mux),
    .addr1mux(addr1mux), .addr2mux(addr2mux), .aluk(aluk),
    .mem_oe(mem_oe), .mem_we(mem_we), .halted(halted)
  );

  always #5 clk = ~clk;

  assign obs = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, drmux, sr1mux,
                sr2mux, addr1mux, addr2mux, aluk, mem_oe, mem_we, halted};

  localparam logic [24:0] LD_MAR   = 25'd1 << 24;
  localparam logic [24:0] LD_MDR   = 25'd1 << 23;
  localparam logic [24:0] LD_IR    = 25'd1 << 22;
  localparam logic [24:0] LD_BEN   = 25'd1 << 21;
  localparam logic [24:0] LD_CC    = 25'd1 << 20;
  localparam logic [24:0] LD_REG   = 25'd1 << 19;
  localparam logic [24:0] LD_PC    = 25'd1 << 18;
  localparam logic [24:0] LD_LED   = 25'd1 << 17;
  localparam logic [24:0] G_PC     = 25'd1 << 16;
  localparam logic [24:0] G_MDR    = 25'd1 << 15;
  localparam logic [24:0] G_ALU    = 25'd1 << 14;
  localparam logic [24:0] G_MARMUX = 25'd1 << 13;
  localparam logic [24:0] DRMUX    = 25'd1 << 10;
  localparam logic [24:0] SR1      = 25'd1 << 9;
  localparam logic [24:0] SR2      = 25'd1 << 8;
  localparam logic [24:0] A1       = 25'd1 << 7;
  localparam logic [24:0] MEM_OE   = 25'd1 << 2;
  localparam logic [24:0] MEM_WE   = 25'd1 << 1;
  localparam logic [24:0] HALT     = 25'd1;

  function automatic logic [24:0] pcm(input logic [1:0] x);
    return {12'd0, x, 11'd0};
  endfunction
  function automatic logic [24:0] a2m(input logic [1:0] x);
    return {18'd0, x, 5'd0};
  endfunction
  function automatic logic [24:0] alk(input logic [1:0] x);
    return {20'd0, x, 3'd0};
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [3:0] ro();
    return 4'($urandom_range(0, 15));
  endfunction

  int total = 0;
  int bad = 0;
  bit halted_model = 1'b1;
  logic [3:0] cur_op;
  logic cur_i5, cur_i11;

  string       tq[$];
  logic [24:0] eq[$];
  logic [3:0]  oq[$];
  logic        i5q[$], i11q[$], bq[$], cq[$], rq[$];

  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic add(input string t, input logic [24:0] e, input logic [3:0] op, input logic i5,
                     input logic i11, input logic b, input logic c, input logic r);
    tq.push_back(t); eq.push_back(e); oq.push_back(op); i5q.push_back(i5);
    i11q.push_back(i11); bq.push_back(b); cq.push_back(c); rq.push_back(r);
  endtask

  // execute-phase cycle: instruction fields held, unrelated inputs random
  task automatic ex(input string t, input logic [24:0] e);
    add(t, e, cur_op, cur_i5, cur_i11, rb(), rb(), rb());
  endtask

  task automatic plan(input logic [3:0] op, input logic i5, input logic i11, input logic bv);
    int p1, p2;
    cur_op = op; cur_i5 = i5; cur_i11 = i11;
    if (halted_model) begin
      p1 = $urandom_range(0, 2);
      for (int j = 0; j < p1; j++) add("halted", HALT, ro(), rb(), rb(), rb(), rb(), 1'b0);
      add("halted", HALT, ro(), rb(), rb(), rb(), rb(), 1'b1);
      halted_model = 1'b0;
    end
    add("fetch1", LD_MAR | G_PC | LD_PC, ro(), rb(), rb(), rb(), rb(), rb());
    for (int j = 0; j < int'(MW); j++) add("fetch2", MEM_OE | LD_MDR, ro(), rb(), rb(), rb(), rb(), rb());
    ex("fetch3", G_MDR | LD_IR);
    ex("decode", LD_BEN);
    case (op)
      4'b0001, 4'b0101:
        ex("alu", LD_REG | LD_CC | G_ALU | SR1 | (i5 ? SR2 : 25'd0) | alk((op == 4'b0101) ? 2'd1 : 2'd0));
      4'b1001: ex("not", LD_REG | LD_CC | G_ALU | SR1 | alk(2'd2));
      4'b0000: begin
        add("br_chk", 25'd0, op, i5, i11, bv, rb(), rb());
        if (bv) ex("br_take", LD_PC | pcm(2'd2) | a2m(2'd2));
      end
      4'b1100: ex("jmp", LD_PC | pcm(2'd1) | G_ALU | SR1 | alk(2'd3));
      4'b0100: begin
        ex("jsr", LD_REG | DRMUX | G_PC);
        if (i11) ex("jsr2", LD_PC | pcm(2'd2) | a2m(2'd3));
        else     ex("jsrr2", LD_PC | pcm(2'd1) | G_ALU | SR1 | alk(2'd3));
      end
      4'b0110: begin
        ex("ldr1", LD_MAR | G_MARMUX | A1 | SR1 | a2m(2'd1));
        for (int j = 0; j < int'(MW); j++) ex("ldr2", MEM_OE | LD_MDR);
        ex("ldr3", LD_REG | LD_CC | G_MDR);
      end
      4'b0111: begin
        ex("str1", LD_MAR | G_MARMUX | A1 | SR1 | a2m(2'd1));
        ex("str2", LD_MDR | G_ALU | alk(2'd3));
        for (int j = 0; j < int'(MW); j++) ex("str3", MEM_WE);
      end
      4'b1101: begin
        p1 = $urandom_range(1, 3);
        p2 = $urandom_range(1, 3);
        for (int j = 0; j < p1; j++) add("pause1", LD_LED, op, i5, i11, rb(), (j == p1 - 1), rb());
        for (int j = 0; j < p2; j++) add("pause2", 25'd0, op, i5, i11, rb(), (j != p2 - 1), rb());
      end
      default: begin
`ifdef ISDU_ILLEGAL_HALT_EN
        halted_model = 1'b1;
`endif
      end
    endcase
  endtask

  // check the first n planned cycles, driving each cycle's inputs after its check
  task automatic run_plan(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tq[i], obs, eq[i]);
      chk("gate_onehot", 25'(($countones(obs[16:13]) <= 1)), 25'd1);
      opcode = oq[i]; ir5 = i5q[i]; ir11 = i11q[i];
      ben = bq[i]; continue_i = cq[i]; run = rq[i];
    end
    tq.delete(); eq.delete(); oq.delete(); i5q.delete();
    i11q.delete(); bq.delete(); cq.delete(); rq.delete();
  endtask

  task automatic instr(input logic [3:0] op, input logic i5, input logic i11, input logic bv);
    plan(op, i5, i11, bv);
    run_plan(eq.size());
  endtask

  initial begin
    run = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("reset", obs, HALT);
    end
    rst_n = 1'b1;
    run = 1'b0;

    instr(4'b0001, 1'b1, 1'b0, 1'b0);
    instr(4'b0101, 1'b0, 1'b1, 1'b1);
    instr(4'b1001, 1'b1, 1'b1, 1'b0);
    instr(4'b0000, 1'b0, 1'b0, 1'b1);
    instr(4'b0000, 1'b1, 1'b0, 1'b0);
    instr(4'b1100, 1'b0, 1'b0, 1'b1);
    instr(4'b0100, 1'b0, 1'b1, 1'b0);
    instr(4'b0100, 1'b1, 1'b0, 1'b1);
    instr(4'b0110, 1'b0, 1'b0, 1'b0);
    instr(4'b0111, 1'b1, 1'b1, 1'b1);
    instr(4'b1101, 1'b0, 1'b0, 1'b0);
    instr(4'b1111, 1'b1, 1'b1, 1'b1);
    instr(4'b0010, 1'b0, 1'b1, 1'b0);

    // reset asserted in the middle of the second FETCH2 cycle
    plan(4'b0001, 1'b1, 1'b0, 1'b0);
    run_plan(eq.size() - int'(MW) - 3 + 2);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", obs, HALT);
    @(negedge clk);
    chk("reset_hold", obs, HALT);
    rst_n = 1'b1;
    run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("halted_after_reset", obs, HALT);
    end
    halted_model = 1'b1;

    for (int k = 0; k < 60; k++) instr(ro(), rb(), rb(), rb());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
